// File: rtl/apb_spi_pkg.sv
// apb_spi_pkg: register offsets, STATUS/CTRL bit positions and dispatcher states for apb_spi_frontend.
package apb_spi_pkg;
  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_RXDATA = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_CTRL   = 4'hC;
  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} disp_state_t;
endpackage

// File: rtl/apb_spi_frontend_if.sv
// apb_spi_frontend_if: APB3 bus between the CPU-side master and the SPI front-end slave.
interface apb_spi_frontend_if #(parameter int ADDR_W = 4);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with push/pop/flush; full/empty from pointers carrying an extra wrap bit.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_push;
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = i_pop & !o_empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push  = i_push & (!o_full | w_pop);
  assign o_dout  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= r_wp + {{AW{1'b0}}, w_push};
      r_rp <= r_rp + {{AW{1'b0}}, w_pop};
    end
  always_ff @(posedge clk)
    if (w_push & !i_flush) r_mem[r_wp[AW-1:0]] <= i_din;
endmodule

// File: rtl/apb_spi_frontend.sv
// apb_spi_frontend: zero-wait APB3 slave feeding spi_master from a TX FIFO and collecting bytes into an RX FIFO.
// Define APB_SPI_IRQ_EN to build the registered interrupt and the CTRL.irq_en bit.
module apb_spi_frontend import apb_spi_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  apb_spi_frontend_if.slave apb,
  output logic              spi_start,
  output logic [7:0]        spi_wdata,
  input  logic              spi_ready,
  input  logic              spi_rx_valid,
  input  logic [7:0]        spi_rdata,
  output logic              irq
);
  disp_state_t       r_state;
  disp_state_t       w_next;
  logic              r_en;
  logic              r_rx_ovf;
  logic [7:0]        r_wdata;
  logic [ADDR_W-1:0] w_paddr;
  logic [3:0]        w_addr;
  logic              w_acc, w_wr, w_rd;
  logic              w_sel_tx, w_sel_rx, w_sel_st, w_sel_ctrl;
  logic              w_flush, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [7:0]        w_tx_dout, w_rx_dout;
  logic [31:0]       w_status, w_ctrl;
  logic              w_irq_en;
  logic              w_unused;
  assign w_paddr    = apb.paddr;
  assign w_unused   = ^{w_paddr, apb.pwdata};
  assign w_addr     = {w_paddr[3:2], 2'b00};
  assign w_acc      = apb.psel & apb.penable;
  assign w_wr       = w_acc & apb.pwrite;
  assign w_rd       = w_acc & !apb.pwrite;
  assign w_sel_tx   = w_addr == REG_TXDATA;
  assign w_sel_rx   = w_addr == REG_RXDATA;
  assign w_sel_st   = w_addr == REG_STATUS;
  assign w_sel_ctrl = w_addr == REG_CTRL;
  assign w_flush    = w_wr & w_sel_ctrl & apb.pwdata[CTRL_FLUSH];
  assign w_tx_push  = w_wr & w_sel_tx & !w_tx_full;
  assign w_tx_pop   = r_state == LAUNCH;
  assign w_rx_pop   = w_rd & w_sel_rx & !w_rx_empty;
  assign w_rx_push  = spi_rx_valid & (!w_rx_full | w_rx_pop);
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_flush(w_flush),
    .i_din(apb.pwdata[7:0]), .o_dout(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst_n(rst_n), .i_push(w_rx_push), .i_pop(w_rx_pop), .i_flush(w_flush),
    .i_din(spi_rdata), .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );
  always_comb begin
    w_status = '0;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_BUSY]     = r_state != IDLE;
    w_status[ST_RX_OVF]   = r_rx_ovf;
    w_ctrl = '0;
    w_ctrl[CTRL_EN]     = r_en;
    w_ctrl[CTRL_IRQ_EN] = w_irq_en;
  end
  always_comb begin
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    if (w_acc) begin
      if (w_sel_tx) apb.pslverr = !apb.pwrite | w_tx_full;
      else if (w_sel_rx) begin
        apb.pslverr = apb.pwrite | w_rx_empty;
        apb.prdata  = w_rx_pop ? {24'b0, w_rx_dout} : '0;
      end
      else if (w_sel_st) apb.prdata = w_rd ? w_status : '0;
      else apb.prdata = w_rd ? w_ctrl : '0;
    end
  end
  assign apb.pready = 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_wr & w_sel_ctrl) r_en <= apb.pwdata[CTRL_EN];
      if (spi_rx_valid & w_rx_full & !w_rx_pop) r_rx_ovf <= 1'b1;
      else if (w_wr & w_sel_st & apb.pwdata[ST_RX_OVF]) r_rx_ovf <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == LAUNCH) r_wdata <= w_tx_dout;
    end
  // enable only gates the IDLE exit, so a transfer in flight always completes
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      w_next = (r_en & !w_tx_empty & spi_ready) ? LAUNCH : IDLE;
      LAUNCH:    w_next = WAIT_ACK;
      WAIT_ACK:  w_next = spi_ready ? WAIT_ACK : WAIT_DONE;
      WAIT_DONE: w_next = spi_ready ? IDLE : WAIT_DONE;
      default:   w_next = IDLE;
    endcase
  end
  assign spi_start = r_state == LAUNCH;
  assign spi_wdata = r_wdata;
`ifdef APB_SPI_IRQ_EN
  logic r_irq_en;
  logic r_irq;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr & w_sel_ctrl) r_irq_en <= apb.pwdata[CTRL_IRQ_EN];
      r_irq <= r_irq_en & (w_tx_empty | !w_rx_empty | r_rx_ovf);
    end
  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif
endmodule
